// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
// Optional build macro used by the top: REGFILE_ARB_STATS_EN.
package regfile_arb_pkg;

    localparam int WORD_SIZE_DEFAULT    = 32;
    localparam int ADDRESS_SIZE_DEFAULT = 5;
    localparam int NUM_REQ_DEFAULT      = 2;
    localparam int REG_COUNT            = 1 << ADDRESS_SIZE_DEFAULT;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // Width of a requester index; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts just after the pointer
// and wraps around. The pointer register itself lives in the parent.
module rr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEFAULT,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   winner,
    output logic               any_grant
);

    // Later assignments override earlier ones, so the wrapped range (<= pointer)
    // is scanned first and the preferred range (> pointer) overrides it.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        grant     = '0;
        winner    = '0;
        any_grant = |valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i] && (i <= int'(pointer))) begin
                grant    = '0;
                grant[i] = 1'b1;
                winner   = IDX_W'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (valid[i] && (i > int'(pointer))) begin
                grant    = '0;
                grant[i] = 1'b1;
                winner   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the register-file write port: zero-clear sweep, then round-robin writeback.
// Build macro REGFILE_ARB_STATS_EN adds the contention_cnt output.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEFAULT,
    parameter int ADDRESS_SIZE = ADDRESS_SIZE_DEFAULT,
    parameter int NUM_REQ      = NUM_REQ_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear_req,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
    input  logic [NUM_REQ*WORD_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_RegWrite,
    output logic [ADDRESS_SIZE-1:0]        rf_WriteReg,
    output logic [WORD_SIZE-1:0]           rf_WriteData,
`ifdef REGFILE_ARB_STATS_EN
    output logic                           clear_busy,
    output logic [15:0]                    contention_cnt
`else
    output logic                           clear_busy
`endif
);

    localparam int IDX_W    = idx_width(NUM_REQ);
    localparam int REG_LAST = (1 << ADDRESS_SIZE) - 1;

    state_t                  state, state_nxt;
    logic [ADDRESS_SIZE-1:0] sweep_cnt;
    logic [IDX_W-1:0]        rr_ptr;
    logic [NUM_REQ-1:0]      grant;
    logic [IDX_W-1:0]        winner;
    logic                    any_grant;
    logic                    handshake;
    logic [ADDRESS_SIZE-1:0] sel_addr;
    logic [WORD_SIZE-1:0]    sel_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .valid     (req_valid),
        .pointer   (rr_ptr),
        .grant     (grant),
        .winner    (winner),
        .any_grant (any_grant)
    );

    assign req_ready  = (state == RUN) ? grant : '0;
    assign handshake  = (state == RUN) && any_grant;
    assign clear_busy = (state == CLEAR);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDRESS_SIZE +: ADDRESS_SIZE];
                sel_data = req_data[i*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            CLEAR: if (!clear_req && (sweep_cnt == ADDRESS_SIZE'(REG_LAST))) state_nxt = RUN;
            RUN:   if (clear_req) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_nxt;
        end
    end

    // Write-port outputs are registered: each accepted write appears one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_cnt    <= '0;
            rr_ptr       <= IDX_W'(NUM_REQ - 1);
            rf_RegWrite  <= 1'b0;
            rf_WriteReg  <= '0;
            rf_WriteData <= '0;
        end else if (state == CLEAR) begin
            rf_RegWrite  <= 1'b1;
            rf_WriteReg  <= sweep_cnt;
            rf_WriteData <= '0;
            sweep_cnt    <= clear_req ? '0 : sweep_cnt + 1'b1;
        end else begin
            sweep_cnt <= '0;
            if (handshake) begin
                rf_RegWrite  <= |sel_addr;
                rf_WriteReg  <= sel_addr;
                rf_WriteData <= sel_data;
                rr_ptr       <= winner;
            end else begin
                rf_RegWrite <= 1'b0;
            end
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contention_cnt <= '0;
        end else if ((state == RUN) && ($countones(req_valid) >= 2) && (contention_cnt != 16'hFFFF)) begin
            contention_cnt <= contention_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by randomized
// requester traffic, compared against a cycle-level behavioural model.
module tb_regfile_write_arbiter;

    localparam int W    = 32;
    localparam int A    = 5;
    localparam int N    = 2;
    localparam int REGS = 1 << A;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clear_req = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*A-1:0] req_addr = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           rf_RegWrite;
    logic [A-1:0]   rf_WriteReg;
    logic [W-1:0]   rf_WriteData;
    logic           clear_busy;
`ifdef REGFILE_ARB_STATS_EN
    logic [15:0]    contention_cnt;
`endif

    regfile_write_arbiter #(.WORD_SIZE(W), .ADDRESS_SIZE(A), .NUM_REQ(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear_req      (clear_req),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rf_RegWrite    (rf_RegWrite),
        .rf_WriteReg    (rf_WriteReg),
        .rf_WriteData   (rf_WriteData),
`ifdef REGFILE_ARB_STATS_EN
        .clear_busy     (clear_busy),
        .contention_cnt (contention_cnt)
`else
        .clear_busy     (clear_busy)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: "clearing" plus next sweep address, the last winner,
    // and what the register-file port is expected to show.
    bit           m_clearing;
    int           m_idx;
    int           m_last;
    bit           m_we;
    logic [A-1:0] m_wreg;
    logic [W-1:0] m_wdata;
    int           m_cnt;
    int           g_win;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clearing = 1'b1;
        m_idx      = 0;
        m_last     = N - 1;
        m_we       = 1'b0;
        m_wreg     = '0;
        m_wdata    = '0;
        m_cnt      = 0;
    endtask

    function automatic int pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_port(input string tag);
        check({tag, ".we"},   rf_RegWrite,  m_we);
        check({tag, ".reg"},  rf_WriteReg,  m_wreg);
        check({tag, ".data"}, rf_WriteData, m_wdata);
        check({tag, ".busy"}, clear_busy,   m_clearing);
`ifdef REGFILE_ARB_STATS_EN
        check({tag, ".cnt"},  contention_cnt, 64'(m_cnt));
`endif
    endtask

    // One clock cycle: drive inputs, check ready before the edge, advance the
    // model at the edge, check the registered port just after it.
    task automatic cycle(input string tag, input logic [N-1:0] v, input logic [A-1:0] a0,
                         input logic [W-1:0] d0, input logic [A-1:0] a1,
                         input logic [W-1:0] d1, input logic clr);
        logic [N-1:0] exp_rdy;
        logic [A-1:0] wa;
        logic [W-1:0] wd;
        int           ones;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        clear_req = clr;
        g_win     = m_clearing ? -1 : pick(v);
        exp_rdy   = '0;
        if (g_win >= 0) exp_rdy[g_win] = 1'b1;
        @(negedge clk);
        check({tag, ".ready"}, req_ready, exp_rdy);
        @(posedge clk);
        ones = 0;
        for (int i = 0; i < N; i++) ones += int'(v[i]);
        if (m_clearing) begin
            m_we = 1'b1; m_wreg = A'(m_idx); m_wdata = '0;
            if (clr) m_idx = 0;
            else if (m_idx == REGS - 1) begin m_idx = 0; m_clearing = 1'b0; end
            else m_idx++;
        end else begin
            if (ones >= 2 && m_cnt < 16'hFFFF) m_cnt++;
            if (g_win >= 0) begin
                wa = (g_win == 0) ? a0 : a1;
                wd = (g_win == 0) ? d0 : d1;
                m_we = (wa != 0); m_wreg = wa; m_wdata = wd; m_last = g_win;
            end else begin
                m_we = 1'b0;
            end
            if (clr) begin m_clearing = 1'b1; m_idx = 0; end
        end
        #1;
        check_port(tag);
    endtask

    task automatic idle(input string tag);
        cycle(tag, '0, '0, '0, '0, '0, 1'b0);
    endtask

    logic [A-1:0] pa [N];
    logic [W-1:0] pd [N];
    logic [N-1:0] pv;
    logic [1:0]   grants;
    logic         clr;

    initial begin
        // Reset with both requesters already asserting: ready must stay low.
        model_reset();
        req_valid = '1;
        #1;
        check_port("reset");
        check("reset.ready", req_ready, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Sweep 0..31 while both requesters wait, then they alternate 0,1,0,1.
        for (int i = 0; i < REGS; i++) cycle("sweep", 2'b11, 5'd3, 32'h3333, 5'd7, 32'h7777, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle("rr", 2'b11, 5'd3, 32'h3333, 5'd7, 32'h7777, 1'b0);
            grants = 2'(g_win);
            check("rr.winner", grants, 2'(i % 2));
        end
        idle("idle");

        cycle("single", 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0);
        check("single.reg", rf_WriteReg, 5'd5);
        idle("idle");

        cycle("zero", 2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFFFFFF, 1'b0);
        check("zero.we", rf_RegWrite, 1'b0);

        // Handshake and clear_req together: addr 9 write first, then a fresh sweep.
        cycle("clr_hs", 2'b01, 5'd9, 32'h0000_0909, 5'd0, 32'h0, 1'b1);
        check("clr_hs.reg", rf_WriteReg, 5'd9);
        for (int i = 0; i < REGS; i++) cycle("sweep2", 2'b11, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0);
        idle("idle");

        // Async reset while the sweep counter sits at 12.
        cycle("clr_go", '0, '0, '0, '0, '0, 1'b1);
        for (int i = 0; i < 40 && !(m_clearing && m_idx == 12); i++) idle("to12");
        check("at12.reg", rf_WriteReg, 5'd11);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_port("mid_rst");
        check("mid_rst.ready", req_ready, '0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < REGS; i++) idle("sweep3");

        // Random traffic obeying the hold-until-accepted rule.
        pv = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && $urandom_range(1, 0) == 1) begin
                    pv[i] = 1'b1;
                    pa[i] = ($urandom_range(7, 0) == 0) ? '0 : A'($urandom);
                    pd[i] = $urandom;
                end
            end
            clr = !m_clearing && ($urandom_range(59, 0) == 0);
            cycle("rand", pv, pa[0], pd[0], pa[1], pd[1], clr);
            if (g_win >= 0) pv[g_win] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the register file.
- After reset, and on request, it sequences a zero-clear sweep of all registers. It then shares the write port between NUM_REQ writeback requesters (ALU result, memory load, link/PC, ...) using round-robin arbitration and a valid/ready handshake.
- Drives the register file's RegWrite/WriteReg/WriteData from registered outputs, so every write occurs exactly one cycle after acceptance.

Parameters:
- WORD_SIZE, 32, data width of one register.
- ADDRESS_SIZE, 5, register address width; register count = 1<<ADDRESS_SIZE.
- NUM_REQ, 2, number of write requesters (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- clear_req  in  1  one-cycle pulse; restarts the zero-clear sweep.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDRESS_SIZE  flattened target register; requester i in slice i.
- req_data  in  NUM_REQ*WORD_SIZE  flattened write data; requester i in slice i.
- req_ready  out  NUM_REQ  one-hot grant; a handshake completes when valid&ready.
- rf_RegWrite  out  1  to register file RegWrite.
- rf_WriteReg  out  ADDRESS_SIZE  to register file WriteReg.
- rf_WriteData  out  WORD_SIZE  to register file WriteData.
- clear_busy  out  1  high while the sweep is in progress.

Behaviour:
- Reset (rst_n=0, takes effect immediately) sets:
  - state=CLEAR, sweep counter=0, rr pointer=NUM_REQ-1 (so requester 0 has first priority).
  - rf_RegWrite=0, rf_WriteReg=0, rf_WriteData=0, clear_busy=1.
  - req_ready is forced to 0 while in CLEAR.
- State CLEAR:
  - Each cycle, registers rf_RegWrite=1, rf_WriteReg=counter, rf_WriteData=0, then increments the counter.
  - When the counter reaches (1<<ADDRESS_SIZE)-1, that final write issues and the next state is RUN.
  - The sweep takes exactly 1<<ADDRESS_SIZE cycles (32 by default).
  - clear_busy falls in the cycle RUN is entered.
  - req_ready is all zeros throughout.
- State RUN:
  - Arbitration is combinational: scan requesters starting at rr pointer+1 modulo NUM_REQ and grant the first one with req_valid=1.
  - req_ready is one-hot on the winner, or all zeros if nothing is valid. req_ready may depend on req_valid in the same cycle; requesters must not make valid depend on ready.
  - On a handshake, the next cycle registers:
    - rf_WriteReg=addr and rf_WriteData=data of the winner.
    - rf_RegWrite=1, except when addr==0, where rf_RegWrite=0 ($zero protection; the request is still accepted).
  - The rr pointer updates to the winner index only on a handshake.
  - With no handshake, the next cycle has rf_RegWrite=0; WriteReg/WriteData hold their previous values.
  - Throughput: one write per cycle. Sustained contention among k requesters gives each a grant every k cycles.
- Requester rule: once asserted, req_valid with its addr/data stays stable until accepted. The arbiter tolerates violations without locking up.
- clear_req:
  - In RUN: the next state is CLEAR with counter=0. Any handshake completed in the same cycle still performs its write next cycle, and the sweep starts one cycle later.
  - In CLEAR: the counter restarts at 0.
- rst_n asserted mid-sweep or mid-write: abandons everything and returns to reset values; no partial write is emitted.

Optional Feature:
- Macro: REGFILE_ARB_STATS_EN.
- When defined, adds output contention_cnt [15:0]:
  - Increments each RUN cycle in which 2 or more req_valid bits are high.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst_n only; clear_req does not affect it.
- When undefined, the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package regfile_arb_pkg holds:
  - the state enum {CLEAR, RUN};
  - localparam REG_COUNT = 1<<ADDRESS_SIZE;
  - the default width constants.
- Sub-module rr_arbiter (NUM_REQ, purely combinational): inputs valid and pointer; outputs one-hot grant and winner index. The parent owns the pointer register.

Test Plan:
- Reset then idle: rst_n low→high; expect rf_RegWrite=1 for 32 cycles with WriteReg=0..31 and WriteData=0, clear_busy=1 during those cycles then 0, and req_ready=00 during the sweep.
- Single requester: req0 addr=5 data=32'hDEADBEEF valid for 1 cycle in RUN; expect ready0=1 that cycle, then next cycle RegWrite=1, WriteReg=5, WriteData=DEADBEEF.
- Round-robin contention: both valid continuously with distinct addrs 3 and 7; expect grants alternating 0,1,0,1, starting with 0 after reset. With STATS_EN, contention_cnt increments every cycle.
- Zero protection: req1 addr=0 data=FFFFFFFF; expect ready1=1, next cycle RegWrite=0.
- clear_req mid-run: handshake on req0 addr=9 and clear_req in the same cycle; expect the addr-9 write next cycle, then a 32-cycle sweep from 0, with ready=00 throughout.
- Async reset mid-sweep at counter=12: expect outputs to reset immediately and the sweep to restart at 0 after rst_n is released.
